// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches over req/ack with a bounded wait, and hands {pc, instr} to control.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned commit target traps to ERROR instead of being truncated.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    input  logic [31:0] pc_next_in,
    output logic        fetch_err_out
);
    localparam int CW = IMEM_TIMEOUT > 0 ? $clog2(IMEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(IMEM_TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERROR} state_t;

    state_t state, state_d;
    logic [31:0] pc, pc_d, instr, instr_d;
    logic valid, valid_d;
    logic [CW-1:0] cnt, cnt_d;

    always_comb begin
        state_d = state;
        pc_d    = pc;
        instr_d = instr;
        valid_d = valid;
        cnt_d   = cnt;
        case (state)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack_in) begin
                    instr_d = imem_data_in;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = &cnt ? cnt : cnt + CW'(1);
                    if (IMEM_TIMEOUT != 0 && cnt_d == TMO) state_d = ERROR;
                end
            end
            HOLD: begin
                if (instr_ready_in) begin
                    valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                    state_d = pc_next_in[1:0] != 2'b00 ? ERROR : REQ;
                    pc_d    = pc_next_in[1:0] != 2'b00 ? pc : pc_next_in;
`else
                    state_d = REQ;
                    pc_d    = pc_next_in & 32'hFFFF_FFFC;
`endif
                end
            end
            ERROR: valid_d = 1'b0;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            instr <= 32'h0000_0013;
            valid <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            instr <= instr_d;
            valid <= valid_d;
            cnt   <= cnt_d;
        end
    end

    assign imem_req_out    = state == REQ;
    assign imem_addr_out   = pc;
    assign pc_out          = pc;
    assign instr_out       = instr;
    assign instr_valid_out = valid;
    assign fetch_err_out   = state == ERROR;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue scoreboard checked by an independent valid-edge monitor.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in = 1'b0;
    logic [31:0] imem_data_in = '0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid_out;
    logic        instr_ready_in = 1'b0;
    logic [31:0] pc_next_in = '0;
    logic        fetch_err_out;

    int tests = 0;
    int fails = 0;
    int mem_wait = 0;
    bit mem_block = 1'b0;
    logic [63:0] exp_q[$];

    fetch_unit #(.RESET_PC(32'h100), .IMEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_ack_in(imem_ack_in), .imem_data_in(imem_data_in),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid_out(instr_valid_out),
        .instr_ready_in(instr_ready_in), .pc_next_in(pc_next_in),
        .fetch_err_out(fetch_err_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a == 32'h100 ? 32'h0000_0093 :
               a == 32'h104 ? 32'h0100_8193 :
               a == 32'h108 ? 32'h0020_8113 : {16'hDEAD, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Memory: acks after mem_wait idle request cycles, decided at the negedge before the sampling edge.
    initial begin
        int w = 0;
        forever begin
            @(negedge clk);
            imem_ack_in = 1'b0;
            imem_data_in = imem(imem_addr_out);
            if (rst || !imem_req_out || mem_block) w = 0;
            else if (w == mem_wait) begin
                imem_ack_in = 1'b1;
                w = 0;
            end else w++;
        end
    end

    // Monitor: every rising edge of valid must match the oldest expected {pc, instr}.
    initial begin
        logic v_q = 1'b0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (instr_valid_out && !v_q) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: pc %h instr %h with empty queue", pc_out, instr_out);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_pc", pc_out, e[63:32]);
                    check("mon_instr", instr_out, e[31:0]);
                end
            end
            v_q = instr_valid_out;
        end
    end

    task automatic commit(input logic [31:0] nxt);
        instr_ready_in = 1'b1;
        pc_next_in = nxt;
        tick();
        instr_ready_in = 1'b0;
    endtask

    task automatic restart();
        exp_q.push_back({32'h100, 32'h0000_0093});
        mem_wait = 0;
        mem_block = 1'b0;
        rst = 1'b0;
        tick();
        check("restart_req", {31'b0, imem_req_out}, 32'd1);
        check("restart_addr", imem_addr_out, 32'h100);
        tick();
        check("restart_valid", {31'b0, instr_valid_out}, 32'd1);
        check("restart_req_low", {31'b0, imem_req_out}, 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("rst_req", {31'b0, imem_req_out}, 32'd0);
        check("rst_addr", imem_addr_out, 32'h100);
        check("rst_instr", instr_out, 32'h13);
        check("rst_pc", pc_out, 32'h100);
        check("rst_valid", {31'b0, instr_valid_out}, 32'd0);
        check("rst_err", {31'b0, fetch_err_out}, 32'd0);

        // test 1: zero-wait fetch right after the IDLE cycle
        restart();

        // test 3: no commit -> no new request, outputs stable
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_req", {31'b0, imem_req_out}, 32'd0);
            check("hold_instr", instr_out, 32'h0000_0093);
        end
        check("hold_pc", pc_out, 32'h100);

        // test 2: three wait states, address held for four request cycles
        mem_wait = 3;
        exp_q.push_back({32'h104, 32'h0100_8193});
        commit(32'h104);
        check("c2_valid_drop", {31'b0, instr_valid_out}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("c2_req", {31'b0, imem_req_out}, 32'd1);
            check("c2_addr", imem_addr_out, 32'h104);
            tick();
        end
        check("c2_req_low", {31'b0, imem_req_out}, 32'd0);
        check("c2_valid", {31'b0, instr_valid_out}, 32'd1);

        // test 5: misaligned commit target
        mem_wait = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
        commit(32'h10A);
        check("mis_err", {31'b0, fetch_err_out}, 32'd1);
        check("mis_req", {31'b0, imem_req_out}, 32'd0);
        check("mis_pc", pc_out, 32'h104);
        rst = 1'b1;
        tick();
        restart();
`else
        exp_q.push_back({32'h108, 32'h0020_8113});
        commit(32'h10A);
        check("mis_addr", imem_addr_out, 32'h108);
        check("mis_err", {31'b0, fetch_err_out}, 32'd0);
        tick();
        check("mis_valid", {31'b0, instr_valid_out}, 32'd1);
`endif

        // test 4: memory never acks -> error after four request cycles, sticky until rst
        mem_block = 1'b1;
        commit(32'h10C);
        for (int i = 0; i < 4; i++) begin
            check("to_req", {31'b0, imem_req_out}, 32'd1);
            check("to_err_early", {31'b0, fetch_err_out}, 32'd0);
            tick();
        end
        check("to_err", {31'b0, fetch_err_out}, 32'd1);
        check("to_req_low", {31'b0, imem_req_out}, 32'd0);
        instr_ready_in = 1'b1;
        repeat (5) tick();
        instr_ready_in = 1'b0;
        check("to_sticky", {31'b0, fetch_err_out}, 32'd1);
        check("to_valid", {31'b0, instr_valid_out}, 32'd0);
        rst = 1'b1;
        tick();
        check("to_rst_err", {31'b0, fetch_err_out}, 32'd0);
        check("to_rst_pc", pc_out, 32'h100);
        restart();

        // test 6: rst in REQ with a simultaneous ack discards the fetch
        commit(32'h110);
        check("r6_req", {31'b0, imem_req_out}, 32'd1);
        rst = 1'b1;
        tick();
        check("r6_valid", {31'b0, instr_valid_out}, 32'd0);
        check("r6_req_low", {31'b0, imem_req_out}, 32'd0);
        check("r6_pc", pc_out, 32'h100);
        restart();

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
